// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, setup-word field positions and limits for uart_byte_rx.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  localparam int SETUP_DIV_LSB = 0;
  localparam int SETUP_PAR_EN  = 24;
  localparam int SETUP_PAR_ODD = 25;
  localparam int MIN_DIV       = 2;
endpackage

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: setup/serial inputs and byte-strobe outputs of the UART byte receiver.
interface uart_byte_rx_if #(parameter int SETUP_W = 31);
  logic [SETUP_W-1:0] i_setup;
  logic               i_uart_rx;
  logic               o_wr;
  logic [7:0]         o_data;
  logic               o_frame_err;
  logic               o_parity_err;
  logic               o_break;
  modport master (output i_setup, i_uart_rx, input o_wr, o_data, o_frame_err, o_parity_err, o_break);
  modport slave  (input i_setup, i_uart_rx, output o_wr, o_data, o_frame_err, o_parity_err, o_break);
endinterface

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: 2-flop synchronizer for an asynchronous single-bit input, with configurable reset value.
module bit_synchronizer #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: oversampling 8N1 UART byte receiver with frame-error and break detection.
// Defining UART_RX_PARITY_EN adds runtime-selectable even/odd parity (8E1/8O1).
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int SETUP_W = 31,
  parameter int DIV_W   = 24
) (
  input logic i_clk,
  input logic n_btn_rst,
  uart_byte_rx_if.slave bus
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DMIN = DIV_W'(MIN_DIV);
  state_t state, state_n;
  logic rx_s, tick, start_det, wr_q, fe_q, pe_q, brk_q, par_en_q, par_odd_q, par_bad;
  logic [DIV_W-1:0] baud_cnt, div_q, d_in;
  logic [7:0] shift, data_q;
  logic [2:0] bit_idx;
  logic unused_setup;
  assign unused_setup = ^bus.i_setup[SETUP_W-1:DIV_W];
  bit_synchronizer #(.RST_VAL(1'b1)) u_sync (.clk(i_clk), .rst_n(n_btn_rst), .d(bus.i_uart_rx), .q(rx_s));
  assign d_in = bus.i_setup[SETUP_DIV_LSB +: DIV_W] < DMIN ? DMIN : bus.i_setup[SETUP_DIV_LSB +: DIV_W];
  assign tick = baud_cnt == '0;
  assign start_det = state == IDLE && !rx_s;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rx_s ? IDLE : START;
      START:     state_n = !tick ? START : rx_s ? IDLE : DATA;
      DATA:      state_n = !(tick && bit_idx == 3'd7) ? DATA : par_en_q ? PARITY : STOP;
      PARITY:    state_n = tick ? STOP : PARITY;
      STOP:      state_n = !tick ? STOP : rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge n_btn_rst)
    if (!n_btn_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_q    <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state <= state_n;
      wr_q  <= 1'b0;
      if (start_det) begin
        div_q    <= d_in;
        baud_cnt <= (d_in >> 1) - ONE;
        bit_idx  <= '0;
      end else if (state inside {START, DATA, PARITY, STOP}) begin
        baud_cnt <= tick ? div_q - ONE : baud_cnt - ONE;
      end
      if (state == DATA && tick) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == STOP && tick) begin
        wr_q   <= 1'b1;
        data_q <= shift;
        fe_q   <= ~rx_s;
        pe_q   <= par_bad;
        brk_q  <= ~rx_s && shift == 8'h00 && !par_bad;
      end
      if (state == WAIT_HIGH && rx_s) brk_q <= 1'b0;
    end
`ifdef UART_RX_PARITY_EN
  // Parity mode is captured with the divisor so a mid-frame setup change cannot split a frame.
  always_ff @(posedge i_clk or negedge n_btn_rst)
    if (!n_btn_rst) begin
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_bad   <= 1'b0;
    end else if (start_det) begin
      par_en_q  <= bus.i_setup[SETUP_PAR_EN];
      par_odd_q <= bus.i_setup[SETUP_PAR_ODD];
      par_bad   <= 1'b0;
    end else if (state == PARITY && tick) begin
      par_bad <= ^{shift, rx_s} ^ par_odd_q;
    end
`else
  assign par_en_q  = 1'b0;
  assign par_odd_q = 1'b0;
  assign par_bad   = par_odd_q;
`endif
  assign bus.o_wr         = wr_q;
  assign bus.o_data       = data_q;
  assign bus.o_frame_err  = fe_q;
  assign bus.o_parity_err = pe_q;
  assign bus.o_break      = brk_q;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed self-checking bench for uart_byte_rx (parity test needs UART_RX_PARITY_EN).
module tb_uart_byte_rx;
  import uart_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int wr_cyc = 0;
  logic [7:0] last_data = '0, prev_data = '0;
  logic last_fe = 1'b0, last_pe = 1'b0, last_brk = 1'b0;

  uart_byte_rx_if bus ();
  uart_byte_rx dut (.i_clk(clk), .n_btn_rst(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe on the falling edge, well away from the sampling edge.
  always @(negedge clk)
    if (bus.o_wr === 1'b1) begin
      wr_cnt++;
      wr_cyc = cyc;
      prev_data = last_data;
      last_data = bus.o_data;
      last_fe = bus.o_frame_err;
      last_pe = bus.o_parity_err;
      last_brk = bus.o_break;
    end

  task automatic hold(input logic v, input int n);
    bus.i_uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int dd, input int par);
    hold(1'b0, dd);
    for (int i = 0; i < 8; i++) hold(b[i], dd);
    if (par >= 0) hold(par[0], dd);
    hold(stop, dd);
  endtask

  task automatic check_cleared(input string tag);
    n_tests++; if (bus.o_wr !== 1'b0) begin n_fail++; $display("FAIL %s_wr got %b want 0", tag, bus.o_wr); end
    n_tests++; if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL %s_data got %h want 00", tag, bus.o_data); end
    n_tests++; if (bus.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL %s_fe got %b want 0", tag, bus.o_frame_err); end
    n_tests++; if (bus.o_parity_err !== 1'b0) begin n_fail++; $display("FAIL %s_pe got %b want 0", tag, bus.o_parity_err); end
    n_tests++; if (bus.o_break !== 1'b0) begin n_fail++; $display("FAIL %s_brk got %b want 0", tag, bus.o_break); end
  endtask

  task automatic test_reset;
    bus.i_uart_rx = 1'b1;
    bus.i_setup = 31'd16;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;
    hold(1'b1, 5);
  endtask

  task automatic test_basic;
    int t0, w0;
    w0 = wr_cnt; t0 = cyc;
    send_frame(8'h55, 1'b1, 16, -1);
    hold(1'b1, 4);
    n_tests++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL basic_count got %0d want 1", wr_cnt - w0); end
    n_tests++; if (last_data !== 8'h55) begin n_fail++; $display("FAIL basic_data got %h want 55", last_data); end
    n_tests++; if (last_fe !== 1'b0) begin n_fail++; $display("FAIL basic_fe got %b want 0", last_fe); end
    n_tests++; if (last_pe !== 1'b0) begin n_fail++; $display("FAIL basic_pe got %b want 0", last_pe); end
    n_tests++; if (wr_cyc - t0 !== 155) begin n_fail++; $display("FAIL basic_latency got %0d want 155", wr_cyc - t0); end
    hold(1'b1, 20);
    n_tests++; if (bus.o_data !== 8'h55) begin n_fail++; $display("FAIL basic_hold got %h want 55", bus.o_data); end
  endtask

  task automatic test_false_start;
    int w0;
    w0 = wr_cnt;
    hold(1'b0, 5);
    hold(1'b1, 40);
    n_tests++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL false_nowr got %0d want %0d", wr_cnt, w0); end
    n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL false_idle got %0d want %0d", dut.state, IDLE); end
    send_frame(8'hA3, 1'b1, 16, -1);
    hold(1'b1, 4);
    n_tests++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL false_count got %0d want 1", wr_cnt - w0); end
    n_tests++; if (last_data !== 8'hA3) begin n_fail++; $display("FAIL false_data got %h want a3", last_data); end
    n_tests++; if (last_fe !== 1'b0) begin n_fail++; $display("FAIL false_fe got %b want 0", last_fe); end
  endtask

  task automatic test_frame_err;
    int w0;
    w0 = wr_cnt;
    send_frame(8'h3C, 1'b0, 16, -1);
    hold(1'b0, 40);
    n_tests++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", wr_cnt - w0); end
    n_tests++; if (last_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data got %h want 3c", last_data); end
    n_tests++; if (last_fe !== 1'b1) begin n_fail++; $display("FAIL ferr_fe got %b want 1", last_fe); end
    n_tests++; if (last_brk !== 1'b0) begin n_fail++; $display("FAIL ferr_brk got %b want 0", last_brk); end
    n_tests++; if (dut.state !== WAIT_HIGH) begin n_fail++; $display("FAIL ferr_wait got %0d want %0d", dut.state, WAIT_HIGH); end
    hold(1'b1, 20);
    send_frame(8'h81, 1'b1, 16, -1);
    hold(1'b1, 4);
    n_tests++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL ferr_next_count got %0d want 2", wr_cnt - w0); end
    n_tests++; if (last_data !== 8'h81 || last_fe !== 1'b0) begin n_fail++; $display("FAIL ferr_next got %h/%b want 81/0", last_data, last_fe); end
  endtask

  task automatic test_break;
    int w0;
    w0 = wr_cnt;
    hold(1'b0, 12 * 16);
    n_tests++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL brk_count got %0d want 1", wr_cnt - w0); end
    n_tests++; if (last_data !== 8'h00 || last_fe !== 1'b1) begin n_fail++; $display("FAIL brk_frame got %h/%b want 00/1", last_data, last_fe); end
    n_tests++; if (last_brk !== 1'b1) begin n_fail++; $display("FAIL brk_with_wr got %b want 1", last_brk); end
    hold(1'b1, 2);
    n_tests++; if (bus.o_break !== 1'b1) begin n_fail++; $display("FAIL brk_held got %b want 1", bus.o_break); end
    hold(1'b1, 1);
    n_tests++; if (bus.o_break !== 1'b0) begin n_fail++; $display("FAIL brk_fall got %b want 0", bus.o_break); end
    hold(1'b1, 10);
  endtask

  task automatic test_back_to_back;
    int t0, w0;
    w0 = wr_cnt; t0 = cyc;
    send_frame(8'h12, 1'b1, 16, -1);
    send_frame(8'h34, 1'b1, 16, -1);
    hold(1'b1, 4);
    n_tests++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", wr_cnt - w0); end
    n_tests++; if (prev_data !== 8'h12) begin n_fail++; $display("FAIL b2b_first got %h want 12", prev_data); end
    n_tests++; if (last_data !== 8'h34) begin n_fail++; $display("FAIL b2b_second got %h want 34", last_data); end
    n_tests++; if (wr_cyc - t0 !== 315) begin n_fail++; $display("FAIL b2b_latency got %0d want 315", wr_cyc - t0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int t0;
    bus.i_setup = 31'h0100_0010;
    hold(1'b1, 5);
    t0 = cyc;
    send_frame(8'h07, 1'b1, 16, 0);
    hold(1'b1, 4);
    n_tests++; if (last_data !== 8'h07 || last_pe !== 1'b1) begin n_fail++; $display("FAIL par_bad got %h/%b want 07/1", last_data, last_pe); end
    n_tests++; if (wr_cyc - t0 !== 171) begin n_fail++; $display("FAIL par_latency got %0d want 171", wr_cyc - t0); end
    send_frame(8'h07, 1'b1, 16, 1);
    hold(1'b1, 4);
    n_tests++; if (last_pe !== 1'b0 || last_fe !== 1'b0) begin n_fail++; $display("FAIL par_good got %b/%b want 0/0", last_pe, last_fe); end
    bus.i_setup = 31'd16;
    hold(1'b1, 5);
  endtask
`endif

  task automatic test_reset_mid(input int dset, input int dd);
    int t0, w0;
    bus.i_setup = 31'(dset);
    hold(1'b1, 5);
    w0 = wr_cnt;
    hold(1'b0, dd);
    for (int i = 0; i < 4; i++) hold(i[0], dd);
    hold(1'b1, dd / 2);
    rst_n = 1'b0;
    #1;
    check_cleared("rstmid");
    hold(1'b1, 5);
    rst_n = 1'b1;
    hold(1'b1, 5);
    n_tests++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL rstmid_abort got %0d want %0d", wr_cnt, w0); end
    t0 = cyc;
    send_frame(8'hF0, 1'b1, dd, -1);
    hold(1'b1, 4);
    n_tests++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL rstmid_count got %0d want 1", wr_cnt - w0); end
    n_tests++; if (last_data !== 8'hF0 || last_fe !== 1'b0) begin n_fail++; $display("FAIL rstmid_data got %h/%b want f0/0", last_data, last_fe); end
    n_tests++; if (wr_cyc - t0 !== 3 + dd / 2 + 9 * dd) begin n_fail++; $display("FAIL rstmid_latency D=%0d got %0d want %0d", dset, wr_cyc - t0, 3 + dd / 2 + 9 * dd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_break();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid(16, 16);
    test_reset_mid(1, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
